// File: rtl/sign_bit_parser_seq_if.sv
// Handshake bundle for sign_bit_parser_seq.
// Valid/ready: a transfer happens on a rising clk edge where both valid and
// ready are high; the producer holds its payload until that edge, and ready
// may be low for any number of cycles.
//   master : suffix/valid-mask producer and result consumer side
//   slave  : sign_bit_parser_seq side
interface sign_bit_parser_seq_if #(
    parameter int NUM_SAMPLES = 16,
    parameter int SUFFIX_W    = 128
);
    localparam int NUM_W = $clog2(NUM_SAMPLES + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [SUFFIX_W-1:0]    suffix;
    logic [NUM_SAMPLES-1:0] sign_valid;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_SAMPLES-1:0] sign_bit;
    logic [NUM_W-1:0]       sign_num;

    modport master (
        output in_valid,
        input  in_ready,
        output suffix,
        output sign_valid,
        input  out_valid,
        output out_ready,
        input  sign_bit,
        input  sign_num
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  suffix,
        input  sign_valid,
        output out_valid,
        input  out_ready,
        output sign_bit,
        output sign_num
    );
endinterface

// File: rtl/sign_bit_parser_seq.sv
// sign_bit_parser_seq: multi-cycle sign-bit extractor for the entropy-decoder
// suffix path. A group of NUM_SAMPLES samples is walked LANES samples per
// cycle; every sample flagged in sign_valid takes the next unconsumed suffix
// bit, MSB first.
// Optional build macro: SIGNBIT_EARLY_EXIT_EN -- leave PARSE as soon as no
// later chunk holds a set valid bit (results unchanged, latency shorter).
// Handshakes use the valid/ready rule documented in sign_bit_parser_seq_if.
// state_o exposes the FSM state (0=IDLE, 1=PARSE, 2=DONE) for observation.
module sign_bit_parser_seq #(
    parameter int NUM_SAMPLES = 16,
    parameter int LANES       = 4,
    parameter int SUFFIX_W    = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sign_bit_parser_seq_if.slave bus,
    output logic [1:0]           state_o
);
    localparam int C  = NUM_SAMPLES / LANES;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam int PW = $clog2(SUFFIX_W + 1);
    localparam int IW = (SUFFIX_W > 1) ? $clog2(SUFFIX_W) : 1;
    localparam int NW = $clog2(NUM_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARSE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SUFFIX_W-1:0]    suffix_q, suffix_d;
    logic [NUM_SAMPLES-1:0] valid_q, valid_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [KW-1:0]          k_q, k_d;
    logic [NUM_SAMPLES-1:0] sign_bit_q, sign_bit_d;
    logic [NW-1:0]          sign_num_q, sign_num_d;

    // Chunk datapath signals
    int                     chunk_base;
    logic [LANES-1:0]       chunk_valid;
    logic [LANES-1:0]       chunk_bits;
    logic [PW-1:0]          pre_cnt;
    logic [PW-1:0]          bit_pos;
    logic [IW-1:0]          bit_idx;
    logic                   last_chunk;

`ifdef SIGNBIT_EARLY_EXIT_EN
    logic                   rest_any;
`endif

    // State and datapath registers; reset aborts any group in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            suffix_q   <= '0;
            valid_q    <= '0;
            ptr_q      <= '0;
            k_q        <= '0;
            sign_bit_q <= '0;
            sign_num_q <= '0;
        end else begin
            state_q    <= state_d;
            suffix_q   <= suffix_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            k_q        <= k_d;
            sign_bit_q <= sign_bit_d;
            sign_num_q <= sign_num_d;
        end
    end

    // Resolve chunk k: each valid lane reads the suffix bit at ptr plus the
    // number of valid lanes below it; pre_cnt ends as the chunk popcount
    always_comb begin
        chunk_base  = int'(k_q) * LANES;
        chunk_valid = LANES'(valid_q >> chunk_base);
        chunk_bits  = '0;
        pre_cnt     = '0;
        bit_pos     = '0;
        bit_idx     = '0;
        for (int j = 0; j < LANES; j++) begin
            bit_pos = ptr_q + pre_cnt;
            // Index only meaningful for valid lanes, where it never underflows
            bit_idx = IW'(PW'(SUFFIX_W - 1) - bit_pos);
            if (chunk_valid[j]) begin
                chunk_bits[j] = suffix_q[bit_idx];
                pre_cnt       = pre_cnt + PW'(1);
            end
        end
        last_chunk = (k_q == KW'(C - 1));
    end

`ifdef SIGNBIT_EARLY_EXIT_EN
    // Any valid sample left in chunks after the current one?
    always_comb begin
        rest_any = |(valid_q >> (chunk_base + LANES));
    end
`endif

    // Next-state and register updates of the IDLE/PARSE/DONE controller
    always_comb begin
        state_d    = state_q;
        suffix_d   = suffix_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        k_d        = k_q;
        sign_bit_d = sign_bit_q;
        sign_num_d = sign_num_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    suffix_d   = bus.suffix;
                    valid_d    = bus.sign_valid;
                    ptr_d      = '0;
                    k_d        = '0;
                    sign_bit_d = '0;
                    sign_num_d = '0;
                    state_d    = PARSE;
                end
            end
            PARSE: begin
                // sign_bit_q was cleared on accept, so OR-ing the chunk in is exact
                sign_bit_d = sign_bit_q | (NUM_SAMPLES'(chunk_bits) << chunk_base);
                sign_num_d = sign_num_q + NW'(pre_cnt);
                ptr_d      = ptr_q + pre_cnt;
                k_d        = k_q + KW'(1);
                if (last_chunk) begin
                    state_d = DONE;
                end
`ifdef SIGNBIT_EARLY_EXIT_EN
                if (!rest_any) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // No accept here even if in_valid is high; IDLE takes it next cycle
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sign_bit  = sign_bit_q;
    assign bus.sign_num  = sign_num_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sign_bit_parser_seq.sv
// Bench for sign_bit_parser_seq: directed groups with hand-computed results,
// expected responses queued at issue and checked by an output monitor.
module tb_sign_bit_parser_seq;
    localparam int NS = 16;
    localparam int LN = 4;
    localparam int SW = 128;
    localparam int NW = 5;
    localparam int C  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  state_dbg;

    sign_bit_parser_seq_if #(.NUM_SAMPLES(NS), .SUFFIX_W(SW)) bus();

    sign_bit_parser_seq #(.NUM_SAMPLES(NS), .LANES(LN), .SUFFIX_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard ----------------
    logic [NS+NW-1:0] exp_q[$];
    int unsigned      due_q[$];
    logic [NS+NW-1:0] cur;
    int unsigned      cur_due;
    bit               have_cur = 1'b0;

    function automatic int unsigned exp_lat(input logic [NS-1:0] sv);
        int unsigned l;
        logic [NS-1:0] t;
        l = C;
`ifdef SIGNBIT_EARLY_EXIT_EN
        l = 1;
        for (int c = 0; c < C; c++) begin
            t = sv >> (c * LN);
            if ((t & 16'h000F) != 16'h0000) l = c + 1;
        end
`else
        t = sv;
`endif
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on the rising of out_valid, rechecks while held
    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur = 1'b0;
        end else if (bus.out_valid) begin
            if (!have_cur) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got sign_bit=0x%0h sign_num=%0d with nothing expected",
                             bus.sign_bit, bus.sign_num);
                end else begin
                    cur      = exp_q.pop_front();
                    cur_due  = due_q.pop_front();
                    have_cur = 1'b1;
                    check("latency_cycle", cyc, cur_due);
                end
            end
            if (have_cur) begin
                check("sign_bit", 32'(bus.sign_bit), 32'(cur[NS+NW-1:NW]));
                check("sign_num", 32'(bus.sign_num), 32'(cur[NW-1:0]));
                if (bus.out_ready) have_cur = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [NS-1:0] sv, input logic [SW-1:0] sfx,
                        input logic [NS-1:0] exp_sb, input logic [NW-1:0] exp_sn,
                        input bit push);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.sign_valid = sv;
        bus.suffix     = sfx;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
            bus.in_valid = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back({exp_sb, exp_sn});
            due_q.push_back(cyc + 1 + exp_lat(sv));
        end
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.sign_valid = ~sv;
        bus.suffix     = ~sfx;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        bus.in_valid   = 1'b0;
        bus.suffix     = '0;
        bus.sign_valid = '0;
        bus.out_ready  = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 1);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_sign_bit", 32'(bus.sign_bit), 0);
        check("reset_sign_num", 32'(bus.sign_num), 0);
        check("reset_state", 32'(state_dbg), 0);
        rst_n = 1'b1;

        // Directed groups
        send(16'hFFFF, {16'hA5C3, 112'h0},          16'hC3A5, 5'd16, 1'b1);
        send(16'h0101, {2'b01, {126{1'b1}}},        16'h0100, 5'd2,  1'b1);
        send(16'h0000, {SW{1'b1}},                  16'h0000, 5'd0,  1'b1);
        send(16'h000F, {4'b1001, 124'h0},           16'h0009, 5'd4,  1'b1);
        send(16'h8000, {1'b1, 127'h0},              16'h8000, 5'd1,  1'b1);
        send(16'h00F0, {4'b0110, {124{1'b1}}},      16'h0060, 5'd4,  1'b1);
        send(16'hAAAA, {8'b1100_1010, 120'h0},      16'h220A, 5'd8,  1'b1);
        drain();

        // Backpressure in DONE while a second group waits
        bus.out_ready = 1'b0;
        send(16'hFFFF, {16'hA5C3, 112'h0}, 16'hC3A5, 5'd16, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_seen", 32'(bus.out_valid), 1);
        bus.in_valid   = 1'b1;
        bus.sign_valid = 16'h0101;
        bus.suffix     = {2'b01, {126{1'b1}}};
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready), 0);
            check("bp_out_valid_held", 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        send(16'h0101, {2'b01, {126{1'b1}}}, 16'h0100, 5'd2, 1'b1);
        drain();

        // Reset during the second PARSE cycle
        send(16'hFFFF, {16'h1234, 112'h0}, 16'h0000, 5'd0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 0);
        check("rst_mid_sign_bit", 32'(bus.sign_bit), 0);
        check("rst_mid_sign_num", 32'(bus.sign_num), 0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(16'h1234, {5'b10110, 123'h0}, 16'h0224, 5'd5, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
